// File: rtl/mips_bus_fabric.sv
// Memory-mapped interconnect between the MIPS core data port and NUM_SLAVES
// peripherals. The top SEL_W address bits pick a slave; the fabric holds a
// one-hot select plus a read or write strobe until that slave signals ready,
// then returns a one-cycle m_ready pulse with registered read data. Unmapped
// addresses and slaves that never answer complete with m_err and ERR_DATA.
module mips_bus_fabric #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          SEL_W      = 2,
  parameter int unsigned          NUM_SLAVES = 3,
  parameter int unsigned          TIMEOUT    = 16,
  parameter logic [DATA_W-1:0]    ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // master side
  input  logic                         m_req,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic                         m_wr_en,
  input  logic [DATA_W-1:0]            m_wr_data,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         m_ready,
  output logic                         m_err,
  // slave side
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-SEL_W-1:0]      s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  output logic                         s_wen,
  output logic                         s_ren,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  // status
  output logic [7:0]                   err_count
);

  localparam int unsigned     CNT_W        = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]  NUM_SLAVES_W = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                    r_state;
  logic [ADDR_W-SEL_W-1:0]   r_addr;
  logic                      r_wr_en;
  logic [DATA_W-1:0]         r_wr_data;
  logic [CNT_W-1:0]          r_cnt;
  logic [NUM_SLAVES-1:0]     r_sel;
  logic                      r_wen;
  logic                      r_ren;
  logic                      r_ready;
  logic                      r_err;
  logic [DATA_W-1:0]         r_rd_data;
  logic [7:0]                r_err_count;

  logic [SEL_W-1:0]          w_idx;
  logic                      w_mapped;
  logic [NUM_SLAVES-1:0]     w_onehot;
  logic                      w_sel_ready;
  logic [DATA_W-1:0]         w_sel_rd_data;

  assign w_idx    = m_addr[ADDR_W-1 -: SEL_W];
  assign w_mapped = ({1'b0, w_idx} < NUM_SLAVES_W);

  // Decode the incoming index to one-hot and mux the selected slave's
  // ready/read data using the registered select (only one bit can be set).
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_onehot      = '0;
    w_sel_ready   = 1'b0;
    w_sel_rd_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if ({1'b0, w_idx} == (SEL_W + 1)'(i)) w_onehot[i] = 1'b1;
      if (r_sel[i]) begin
        w_sel_ready   = s_ready[i];
        w_sel_rd_data = s_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with all master/slave outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      r_err_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values and ordering within the block does not matter.
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m_req) begin
            r_addr    <= m_addr[ADDR_W-SEL_W-1:0];
            r_wr_en   <= m_wr_en;
            r_wr_data <= m_wr_data;
            r_cnt     <= '0;
            if (w_mapped) begin
              r_state <= ACCESS;
              r_sel   <= w_onehot;
              r_wen   <= m_wr_en;
              r_ren   <= ~m_wr_en;
            end else begin
              // Nobody answers this window: respond straight away.
              r_state   <= RESP;
              r_ready   <= 1'b1;
              r_err     <= 1'b1;
              r_rd_data <= ERR_DATA;
            end
          end
        end

        ACCESS: begin
          if (w_sel_ready) begin
            r_state   <= RESP;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
            r_rd_data <= r_wr_en ? '0 : w_sel_rd_data;
            r_sel     <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= RESP;
            r_ready   <= 1'b1;
            r_err     <= 1'b1;
            r_rd_data <= ERR_DATA;
            r_sel     <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // Requests seen here are ignored; IDLE samples the next one.
          r_state <= IDLE;
          if (r_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_rd_data = r_rd_data;
  assign m_ready   = r_ready;
  assign m_err     = r_err;
  assign s_sel     = r_sel;
  assign s_addr    = r_addr;
  assign s_wr_data = r_wr_data;
  assign s_wen     = r_wen;
  assign s_ren     = r_ren;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_mips_bus_fabric.sv
// Directed bench for mips_bus_fabric (default parameters: 3 slaves,
// TIMEOUT=16). The bench plays the master and all slaves; every expected
// value below is worked out by hand from the fabric's cycle behaviour.
module tb_mips_bus_fabric;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NS     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr_en;
  logic [DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0] m_rd_data;
  logic              m_ready;
  logic              m_err;
  logic [NS-1:0]     s_sel;
  logic [ADDR_W-3:0] s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic              s_wen;
  logic              s_ren;
  logic [NS*DATA_W-1:0] s_rd_data;
  logic [NS-1:0]     s_ready;
  logic [7:0]        err_count;

  int errors = 0;
  int checks = 0;

  mips_bus_fabric dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_wr_en   (m_wr_en),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wr_data (s_wr_data),
    .s_wen     (s_wen),
    .s_ren     (s_ren),
    .s_rd_data (s_rd_data),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    m_req   = 1'b0;
    m_wr_en = 1'b0;
    s_ready = '0;
  endtask

  // Wait for m_ready; cyc is the number of edges taken, or -1 on expiry.
  task automatic wait_ready(input int max_cyc, output int cyc);
    cyc = 0;
    while (!m_ready && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    if (!m_ready) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    m_req     = 1'b1;
    m_addr    = 32'h0000_0010;
    m_wr_en   = 1'b0;
    m_wr_data = '0;
    s_ready   = '1;
    s_rd_data = {3{32'h5555_AAAA}};
    repeat (3) tick();
    checks++; if ({m_ready, m_err, s_wen, s_ren} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {m_ready, m_err, s_wen, s_ren}); end
    checks++; if (m_rd_data !== 32'h0) begin errors++;
      $display("FAIL reset_rd_data: got %h expected 00000000", m_rd_data); end
    checks++; if (s_sel !== 3'b000) begin errors++;
      $display("FAIL reset_sel: got %b expected 000", s_sel); end
    checks++; if (err_count !== 8'd0) begin errors++;
      $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    // Release with the request still up: it is sampled on the next edge.
    s_ready = '0;
    rst_n   = 1'b1;
    tick();
    checks++; if ({s_sel, s_ren} !== 4'b0011) begin errors++;
      $display("FAIL reset_first_req: got sel=%b ren=%b expected sel=001 ren=1", s_sel, s_ren); end
    s_ready = 3'b001;
    s_rd_data[0 +: 32] = 32'h0BAD_F00D;
    tick();
    checks++; if ({m_ready, m_err, m_rd_data} !== {2'b10, 32'h0BAD_F00D}) begin errors++;
      $display("FAIL reset_first_resp: got rdy=%b err=%b data=%h expected 1 0 0badf00d", m_ready, m_err, m_rd_data); end
    idle_bus();
    tick();
  endtask

  task automatic test_read_zero_wait();
    m_req   = 1'b1;
    m_addr  = 32'h0000_0010;
    m_wr_en = 1'b0;
    tick();
    checks++; if ({s_sel, s_ren, s_wen} !== 5'b00110) begin errors++;
      $display("FAIL rd0_strobes: got sel=%b ren=%b wen=%b expected 001 1 0", s_sel, s_ren, s_wen); end
    checks++; if (s_addr !== 30'h10) begin errors++;
      $display("FAIL rd0_s_addr: got %h expected 10", s_addr); end
    s_ready = 3'b001;
    s_rd_data[0 +: 32] = 32'h1234_5678;
    tick();
    checks++; if ({m_ready, m_err} !== 2'b10) begin errors++;
      $display("FAIL rd0_ready: got rdy=%b err=%b expected 1 0", m_ready, m_err); end
    checks++; if (m_rd_data !== 32'h1234_5678) begin errors++;
      $display("FAIL rd0_data: got %h expected 12345678", m_rd_data); end
    checks++; if ({s_sel, s_ren} !== 4'b0000) begin errors++;
      $display("FAIL rd0_resp_strobes: got sel=%b ren=%b expected 000 0", s_sel, s_ren); end
    idle_bus();
    tick();
    checks++; if (m_ready !== 1'b0) begin errors++;
      $display("FAIL rd0_pulse_width: got %b expected 0", m_ready); end
  endtask

  task automatic test_write_wait();
    int wen_cycles = 0;
    int early      = 0;
    m_req     = 1'b1;
    m_addr    = 32'h4000_0004;
    m_wr_en   = 1'b1;
    m_wr_data = 32'h0000_00A5;
    tick();
    checks++; if ({s_sel, s_addr, s_wr_data} !== {3'b010, 30'h4, 32'hA5}) begin errors++;
      $display("FAIL wr_bus: got sel=%b addr=%h data=%h expected 010 4 a5", s_sel, s_addr, s_wr_data); end
    // Three wait states; unselected slaves shout ready meanwhile.
    for (int k = 1; k <= 4; k++) begin
      if (s_wen && !s_ren && s_sel == 3'b010) wen_cycles++;
      if (m_ready) early++;
      s_ready = (k == 4) ? 3'b010 : 3'b101;
      tick();
    end
    checks++; if (wen_cycles !== 4) begin errors++;
      $display("FAIL wr_wen_cycles: got %0d expected 4", wen_cycles); end
    checks++; if (early !== 0) begin errors++;
      $display("FAIL wr_early_ready: got %0d expected 0", early); end
    checks++; if ({m_ready, m_err, m_rd_data} !== {2'b10, 32'h0}) begin errors++;
      $display("FAIL wr_resp: got rdy=%b err=%b data=%h expected 1 0 00000000", m_ready, m_err, m_rd_data); end
    idle_bus();
    tick();
  endtask

  task automatic test_unmapped();
    m_req   = 1'b1;
    m_addr  = 32'hC000_0000;
    m_wr_en = 1'b0;
    s_ready = '1;
    tick();
    checks++; if (s_sel !== 3'b000) begin errors++;
      $display("FAIL unmap_sel: got %b expected 000", s_sel); end
    checks++; if ({m_ready, m_err, m_rd_data} !== {2'b11, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL unmap_resp: got rdy=%b err=%b data=%h expected 1 1 deadbeef", m_ready, m_err, m_rd_data); end
    idle_bus();
    tick();
    checks++; if (err_count !== 8'd1) begin errors++;
      $display("FAIL unmap_err_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_back_to_back();
    m_req   = 1'b1;
    m_addr  = 32'h4000_0100;
    m_wr_en = 1'b0;
    tick();
    s_ready = 3'b010;
    s_rd_data[32 +: 32] = 32'h1111_2222;
    tick();
    checks++; if ({m_ready, m_rd_data} !== {1'b1, 32'h1111_2222}) begin errors++;
      $display("FAIL b2b_first: got rdy=%b data=%h expected 1 11112222", m_ready, m_rd_data); end
    // Request stays up through RESP with a new transaction.
    s_ready   = '0;
    m_addr    = 32'h0000_0008;
    m_wr_en   = 1'b1;
    m_wr_data = 32'h0000_0077;
    tick();
    checks++; if ({m_ready, s_sel} !== 4'b0000) begin errors++;
      $display("FAIL b2b_idle_gap: got rdy=%b sel=%b expected 0 000", m_ready, s_sel); end
    tick();
    checks++; if ({s_sel, s_wen, s_addr} !== {3'b001, 1'b1, 30'h8}) begin errors++;
      $display("FAIL b2b_second_bus: got sel=%b wen=%b addr=%h expected 001 1 8", s_sel, s_wen, s_addr); end
    s_ready = 3'b001;
    tick();
    checks++; if ({m_ready, m_err, m_rd_data} !== {2'b10, 32'h0}) begin errors++;
      $display("FAIL b2b_second_resp: got rdy=%b err=%b data=%h expected 1 0 00000000", m_ready, m_err, m_rd_data); end
    idle_bus();
    tick();
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int ren = 0;
    m_req   = 1'b1;
    m_addr  = 32'h8000_0020;
    m_wr_en = 1'b0;
    s_ready = 3'b011;
    do begin
      tick();
      cyc++;
      if (s_ren && s_sel == 3'b100) ren++;
    end while (!m_ready && cyc < 40);
    checks++; if (cyc !== 17) begin errors++;
      $display("FAIL to_latency: got %0d expected 17", cyc); end
    checks++; if (ren !== 16) begin errors++;
      $display("FAIL to_ren_cycles: got %0d expected 16", ren); end
    checks++; if ({m_ready, m_err, m_rd_data} !== {2'b11, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL to_resp: got rdy=%b err=%b data=%h expected 1 1 deadbeef", m_ready, m_err, m_rd_data); end
    idle_bus();
    tick();
    checks++; if (err_count !== 8'd2) begin errors++;
      $display("FAIL to_err_count: got %0d expected 2", err_count); end
  endtask

  // 298 more timeouts bring the total to 300 errors.
  task automatic test_err_saturate();
    int cyc;
    bit stuck = 1'b0;
    for (int n = 0; n < 298 && !stuck; n++) begin
      m_req   = 1'b1;
      m_addr  = 32'h8000_0000;
      m_wr_en = 1'b0;
      wait_ready(40, cyc);
      if (cyc < 0) begin
        stuck = 1'b1;
        checks++; errors++;
        $display("FAIL sat_no_ready: transaction %0d got no m_ready in 40 cycles", n);
      end
      idle_bus();
      tick();
      if (n == 251) begin
        checks++; if (err_count !== 8'd254) begin errors++;
          $display("FAIL sat_254: got %0d expected 254", err_count); end
      end
    end
    checks++; if (err_count !== 8'd255) begin errors++;
      $display("FAIL sat_255: got %0d expected 255", err_count); end
  endtask

  task automatic test_reset_mid_access();
    int rdy = 0;
    int cyc;
    m_req   = 1'b1;
    m_addr  = 32'h8000_0004;
    m_wr_en = 1'b0;
    s_ready = '0;
    tick();
    tick();
    checks++; if ({s_sel, s_ren} !== 4'b1001) begin errors++;
      $display("FAIL mid_pre: got sel=%b ren=%b expected 100 1", s_sel, s_ren); end
    rst_n = 1'b0;
    #1;
    checks++; if ({s_sel, s_ren, m_ready} !== 5'b00000) begin errors++;
      $display("FAIL mid_async_drop: got sel=%b ren=%b rdy=%b expected 000 0 0", s_sel, s_ren, m_ready); end
    m_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      if (m_ready) rdy++;
    end
    checks++; if (rdy !== 0) begin errors++;
      $display("FAIL mid_no_ready: got %0d pulses expected 0", rdy); end
    checks++; if (err_count !== 8'd0) begin errors++;
      $display("FAIL mid_err_count: got %0d expected 0", err_count); end
    m_req   = 1'b1;
    m_addr  = 32'h8000_0040;
    s_ready = 3'b100;
    s_rd_data[64 +: 32] = 32'hCAFE_F00D;
    wait_ready(5, cyc);
    checks++; if (cyc !== 2) begin errors++;
      $display("FAIL mid_after_latency: got %0d expected 2", cyc); end
    checks++; if ({m_err, m_rd_data} !== {1'b0, 32'hCAFE_F00D}) begin errors++;
      $display("FAIL mid_after_data: got err=%b data=%h expected 0 cafef00d", m_err, m_rd_data); end
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_unmapped();
    test_back_to_back();
    test_timeout();
    test_err_saturate();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_fabric.md
Name: mips_bus_fabric

Overview:
- Parametrised memory-mapped interconnect between the MIPS core data port and NUM_SLAVES peripherals (memory, UART, timers, and so on).
- Decodes the top SEL_W address bits into a slave index.
- Drives a per-slave select/strobe handshake and waits for the slave's ready.
- Returns registered read data.
- Reports an error response for unmapped addresses and slave timeouts.
- Sits at the top level in place of a fixed one-bit memory/UART split.

Parameters:
- ADDR_W, 32, master address width.
- DATA_W, 32, data width.
- SEL_W, 2, number of top address bits used as the slave index.
- NUM_SLAVES, 3, populated slaves (1..2**SEL_W); indices at or above this value are unmapped.
- TIMEOUT, 16, maximum number of ACCESS cycles before the fabric aborts with an error (minimum 2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- m_req  in  1  master request; held with m_addr, m_wr_data and m_wr_en stable until m_ready.
- m_addr  in  ADDR_W  master address.
- m_wr_en  in  1  1 = write, 0 = read.
- m_wr_data  in  DATA_W  write data.
- m_rd_data  out  DATA_W  registered read data, valid while m_ready is high.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, valid while m_ready is high.
- s_sel  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  ADDR_W-SEL_W  slave-local address (m_addr low bits), broadcast to all slaves.
- s_wr_data  out  DATA_W  broadcast write data.
- s_wen  out  1  write strobe, qualified by s_sel.
- s_ren  out  1  read strobe, qualified by s_sel.
- s_rd_data  in  NUM_SLAVES*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W].
- s_ready  in  NUM_SLAVES  per-slave ready/acknowledge.
- err_count  out  8  saturating count of error responses.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - m_ready=0, m_err=0, m_rd_data=0.
  - s_sel=0, s_wen=0, s_ren=0.
  - Timeout counter=0, err_count=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_req=1, latch idx = m_addr[ADDR_W-1 -: SEL_W], m_addr, m_wr_en and m_wr_data.
  - If idx >= NUM_SLAVES: go to RESP with err=1 and rd_data=ERR_DATA. No slave is selected.
  - Otherwise go to ACCESS with the timeout counter cleared.
- ACCESS:
  - s_sel[idx]=1, s_wen=wr_en, s_ren=~wr_en. All are held every cycle until the access ends.
  - s_addr and s_wr_data come from the latched values.
  - If s_ready[idx]=1: capture s_rd_data[idx] into m_rd_data (writes capture 0) and go to RESP with err=0.
  - Else if the counter equals TIMEOUT-1: go to RESP with err=1 and rd_data=ERR_DATA.
  - Else increment the counter.
  - s_ready bits of unselected slaves are ignored.
- RESP:
  - m_ready=1 for exactly one cycle; m_err reflects the latched error.
  - err_count increments on an error and saturates at 255.
  - All s_* strobes are 0.
  - Next state is IDLE unconditionally. An m_req high during RESP is ignored; the next request is sampled in IDLE.
- Latency:
  - Zero-wait slave (s_ready in the first ACCESS cycle): m_ready occurs 2 cycles after m_req is sampled in IDLE.
  - Unmapped address: m_ready occurs 1 cycle after sampling.
  - Timeout: m_ready occurs TIMEOUT+1 cycles after sampling.
- m_rd_data holds its value outside RESP until the next capture; it is only required to be valid while m_ready=1.
- Strobes are never asserted to two slaves at once. s_sel is all-zero outside ACCESS.
- Reset asserted mid-ACCESS aborts immediately: strobes drop asynchronously and no m_ready is issued.
- m_req dropping during ACCESS is a protocol violation; the fabric completes the latched transaction regardless.

Test Plan:
- Reset with m_req=1 held -> all outputs 0 while rst_n=0. First request is sampled in the cycle after rst_n rises.
- Read from slave 0: m_addr=32'h0000_0010; slave 0 returns ready with 32'h1234_5678 in the first ACCESS cycle -> s_sel=3'b001, s_ren=1, s_addr=30'h10, then m_ready=1, m_rd_data=32'h1234_5678, m_err=0, 2 cycles after the request.
- Write to slave 1 with 3 wait states: m_addr=32'h4000_0004, data 32'hA5, s_ready[1] high in the 4th ACCESS cycle -> s_wen held 4 cycles, then m_ready=1, m_err=0.
- Unmapped access: m_addr=32'hC000_0000 with NUM_SLAVES=3 -> no s_sel, then m_ready 1 cycle later with m_err=1, m_rd_data=32'hDEAD_BEEF; err_count=1.
- Timeout: read from slave 2 that never readies, TIMEOUT=16 -> s_ren held 16 cycles, then m_ready with m_err=1, m_rd_data=ERR_DATA. 300 such errors -> err_count=255.
- Reset mid-ACCESS at the 2nd wait cycle -> s_sel/s_ren drop with rst_n; no m_ready. A following request completes normally.
